npu_mac_array: RTL and testbench

Parametrised, host-mapped multiply-accumulate engine and the successor to the fixed 3-lane conv/FCN datapath. It provides `NUM_PE` signed MAC lanes, multi-tap accumulation, and two modes: lane-reduce (convolution) and lane-independent (fully connected). A post-processing stage applies shift, ReLU and saturation, and results are buffered in an output FIFO that the CPU drains through the same 32-bit register port.

---
 rtl/npu_mac_array_if.sv | 11 +
 rtl/npu_mac_array.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_npu_mac_array.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/npu_mac_array_if.sv
// Host register port of npu_mac_array: one 32-bit read or write per cycle.
interface npu_mac_array_if;
   logic        ena;
   logic        wea;
   logic [15:0] addra;
   logic [31:0] dina;
   logic [31:0] douta;

   modport master (output ena, wea, addra, dina, input douta);
   modport slave  (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/npu_mac_array.sv
// Host-mapped NUM_PE-lane signed MAC engine with post-processing and output FIFO.
// Optional NPU_MAC_SAT_EN: saturate the 16-bit output stage instead of wrapping it.
module npu_mac_array #(
   parameter int NUM_PE      = 4,
   parameter int ACC_W       = 24,
   parameter int K_MAX       = 9,
   parameter int OFIFO_DEPTH = 8
) (
   input logic            clk,
   input logic            rst,
   npu_mac_array_if.slave host_if
);
   localparam int PW = ACC_W + 2;
   localparam int AW = $clog2(OFIFO_DEPTH);
   localparam int LW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

`ifdef NPU_MAC_SAT_EN
   localparam logic signed [PW-1:0] SAT_MAX = PW'(32'sd32767);
   localparam logic signed [PW-1:0] SAT_MIN = PW'(-32'sd32768);
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MAC    = 3'd1,
      S_REDUCE = 3'd2,
      S_POST   = 3'd3,
      S_PUSH   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              act_q [NUM_PE];
   logic [7:0]              wgt_q [NUM_PE];
   logic signed [ACC_W-1:0] acc_q [NUM_PE];
   logic [3:0]              tap_q;
   logic [3:0]              cfg_taps_q;
   logic                    cfg_relu_q;
   logic                    cfg_act_signed_q;
   logic [2:0]              cfg_shift_q;
   logic                    cfg_mode_q;
   logic signed [PW-1:0]    sum_q;
   logic [31:0]             res_q [NUM_PE];
   logic                    indep_q;
   logic [LW-1:0]           push_idx_q;
   logic [31:0]             fifo_mem_q [OFIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [AW:0]             count_q;
   logic                    err_busy_q, err_under_q;
   logic [31:0]             douta_q;

   logic [2:0]              sel_s;
   logic                    wr_s, rd_s, cmd_wr_s;
   logic                    clr_s, flush_s, step_s, step_go_s;
   logic                    status_rd_s, res_rd_s;
   logic                    busy_s, full_s, empty_s;
   logic                    push_s, fifo_wr_s, pop_s, last_word_s;
   logic [3:0]              taps_eff_s;
   logic [8:0]              ext_act_s  [NUM_PE];
   logic signed [16:0]      prod_s     [NUM_PE];
   logic signed [ACC_W-1:0] acc_next_s [NUM_PE];
   logic signed [PW-1:0]    sum_s;
   logic [31:0]             post_lane_s [NUM_PE];
   logic [31:0]             post_sum_s;
   logic [31:0]             status_s;
   logic [31:0]             rdata_s;
   logic                    unused_bus_s;

   // Shift, ReLU, then limit to 16 bits; result returned sign-extended to 32 bits.
   function automatic logic [31:0] post_fn(input logic signed [PW-1:0] x,
                                           input logic [2:0]           sh,
                                           input logic                 relu);
      logic signed [PW-1:0] shifted;
      logic signed [PW-1:0] s;
      logic [15:0]          r;
      shifted = x >>> sh;
      if (relu && shifted[PW-1]) begin
         s = {PW{1'b0}};
      end else begin
         s = shifted;
      end
`ifdef NPU_MAC_SAT_EN
      if (s > SAT_MAX) begin
         r = 16'h7FFF;
      end else if (s < SAT_MIN) begin
         r = 16'h8000;
      end else begin
         r = s[15:0];
      end
`else
      r = s[15:0];
`endif
      return {{16{r[15]}}, r};
   endfunction

   assign sel_s        = host_if.addra[14:12];
   assign unused_bus_s = ^{host_if.addra[15], host_if.addra[11:0], host_if.dina[31:12]};
   assign wr_s         = host_if.ena & host_if.wea;
   assign rd_s         = host_if.ena & ~host_if.wea;
   assign cmd_wr_s     = wr_s & (sel_s == 3'd3);
   // CLR excludes FLUSH and STEP; FLUSH excludes STEP.
   assign clr_s        = cmd_wr_s & host_if.dina[1];
   assign flush_s      = cmd_wr_s & ~host_if.dina[1] & host_if.dina[2];
   assign step_s       = cmd_wr_s & ~host_if.dina[1] & ~host_if.dina[2] & host_if.dina[0];
   assign status_rd_s  = rd_s & (sel_s == 3'd5);
   assign res_rd_s     = rd_s & (sel_s == 3'd6);
   assign busy_s       = (state_q != S_IDLE);
   assign step_go_s    = step_s & ~busy_s;
   assign full_s       = (count_q == (AW+1)'(OFIFO_DEPTH));
   assign empty_s      = (count_q == {(AW+1){1'b0}});
   assign last_word_s  = indep_q ? (push_idx_q == LW'(NUM_PE - 1)) : 1'b1;
   assign push_s       = (state_q == S_PUSH) & ~full_s & ~clr_s;
   assign fifo_wr_s    = push_s & ~flush_s;
   assign pop_s        = res_rd_s & ~empty_s;
   assign host_if.douta = douta_q;

   // Effective tap count: 0 means 1, anything above K_MAX is clamped.
   always_comb begin
      if (cfg_taps_q == 4'd0) begin
         taps_eff_s = 4'd1;
      end else if (cfg_taps_q > 4'(K_MAX)) begin
         taps_eff_s = 4'(K_MAX);
      end else begin
         taps_eff_s = cfg_taps_q;
      end
   end

   // Per-lane 9x8 product, next accumulator, lane sum and post-processed values.
   always_comb begin
      sum_s = {PW{1'b0}};
      for (int p = 0; p < NUM_PE; p++) begin
         ext_act_s[p]   = {cfg_act_signed_q & act_q[p][7], act_q[p]};
         prod_s[p]      = $signed({{8{ext_act_s[p][8]}}, ext_act_s[p]}) *
                          $signed({{9{wgt_q[p][7]}}, wgt_q[p]});
         acc_next_s[p]  = acc_q[p] + {{(ACC_W-17){prod_s[p][16]}}, prod_s[p]};
         sum_s          = sum_s + {{2{acc_q[p][ACC_W-1]}}, acc_q[p]};
         post_lane_s[p] = post_fn({{2{acc_q[p][ACC_W-1]}}, acc_q[p]}, cfg_shift_q, cfg_relu_q);
      end
      post_sum_s = post_fn(sum_q, cfg_shift_q, cfg_relu_q);
   end

   // Next-state logic; CLR aborts from any state.
   always_comb begin
      state_d = state_q;
      if (clr_s) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (step_go_s) state_d = S_MAC;
               else           state_d = S_IDLE;
            end
            S_MAC: begin
               if ((tap_q + 4'd1) >= taps_eff_s) state_d = S_REDUCE;
               else                              state_d = S_IDLE;
            end
            S_REDUCE: state_d = S_POST;
            S_POST:   state_d = S_PUSH;
            S_PUSH: begin
               if (push_s && last_word_s) state_d = S_PUSH == S_PUSH ? S_IDLE : S_PUSH;
               else                       state_d = S_PUSH;
            end
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Read mux for the registered read port.
   always_comb begin
      status_s = {16'h0000, 8'(count_q), 3'b000, err_under_q, err_busy_q, full_s, empty_s, busy_s};
      case (sel_s)
         3'd5:    rdata_s = status_s;
         3'd6:    rdata_s = empty_s ? 32'h0000_0000 : fifo_mem_q[rd_ptr_q];
         default: rdata_s = 32'h0000_0000;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Host-written operand and configuration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PE; p++) begin
            act_q[p] <= 8'h00;
            wgt_q[p] <= 8'h00;
         end
         cfg_taps_q       <= 4'd0;
         cfg_relu_q       <= 1'b0;
         cfg_act_signed_q <= 1'b0;
         cfg_shift_q      <= 3'd0;
         cfg_mode_q       <= 1'b0;
      end else if (wr_s) begin
         for (int p = 0; p < NUM_PE; p++) begin
            if (sel_s == 3'd1) act_q[p] <= host_if.dina[8*p +: 8];
            if (sel_s == 3'd2) wgt_q[p] <= host_if.dina[8*p +: 8];
         end
         if (sel_s == 3'd4) begin
            cfg_taps_q       <= host_if.dina[3:0];
            cfg_relu_q       <= host_if.dina[4];
            cfg_act_signed_q <= host_if.dina[5];
            cfg_shift_q      <= host_if.dina[10:8];
            cfg_mode_q       <= host_if.dina[11];
         end
      end
   end

   // Accumulators, tap counter and the reduce/post/push pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PE; p++) begin
            acc_q[p] <= {ACC_W{1'b0}};
            res_q[p] <= 32'h0000_0000;
         end
         tap_q      <= 4'd0;
         sum_q      <= {PW{1'b0}};
         indep_q    <= 1'b0;
         push_idx_q <= {LW{1'b0}};
      end else begin
         if (clr_s || (push_s && last_word_s)) begin
            for (int p = 0; p < NUM_PE; p++) acc_q[p] <= {ACC_W{1'b0}};
            tap_q <= 4'd0;
         end else if (state_q == S_MAC) begin
            for (int p = 0; p < NUM_PE; p++) acc_q[p] <= acc_next_s[p];
            tap_q <= tap_q + 4'd1;
         end
         if (state_q == S_REDUCE) sum_q <= sum_s;
         if (state_q == S_POST) begin
            indep_q    <= cfg_mode_q;
            push_idx_q <= {LW{1'b0}};
            for (int p = 0; p < NUM_PE; p++) begin
               if (cfg_mode_q)  res_q[p] <= post_lane_s[p];
               else if (p == 0) res_q[p] <= post_sum_s;
               else             res_q[p] <= 32'h0000_0000;
            end
         end else if (push_s) begin
            push_idx_q <= push_idx_q + LW'(1'b1);
         end
      end
   end

   // FIFO pointers and occupancy; FLUSH overrides a simultaneous push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else if (flush_s) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         if (fifo_wr_s) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
         if (pop_s)     rd_ptr_q <= rd_ptr_q + AW'(1'b1);
         case ({fifo_wr_s, pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1'b1);
            2'b01:   count_q <= count_q - (AW+1)'(1'b1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; contents are only observable through count, so no reset.
   always_ff @(posedge clk) begin
      if (fifo_wr_s) fifo_mem_q[wr_ptr_q] <= res_q[push_idx_q];
   end

   // Sticky error flags (cleared by a STATUS read) and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_busy_q  <= 1'b0;
         err_under_q <= 1'b0;
         douta_q     <= 32'h0000_0000;
      end else begin
         if (status_rd_s) begin
            err_busy_q  <= 1'b0;
            err_under_q <= 1'b0;
         end else begin
            if (step_s && busy_s)    err_busy_q  <= 1'b1;
            if (res_rd_s && empty_s) err_under_q <= 1'b1;
         end
         if (rd_s) douta_q <= rdata_s;
      end
   end
endmodule

// File: tb/tb_npu_mac_array.sv
// Scoreboard bench for npu_mac_array: reads queue expected values, a monitor checks douta.
module tb_npu_mac_array;
   localparam logic [2:0] SEL_ACT  = 3'd1;
   localparam logic [2:0] SEL_WGT  = 3'd2;
   localparam logic [2:0] SEL_CMD  = 3'd3;
   localparam logic [2:0] SEL_CFG  = 3'd4;
   localparam logic [2:0] SEL_STAT = 3'd5;
   localparam logic [2:0] SEL_RES  = 3'd6;
`ifdef NPU_MAC_SAT_EN
   localparam logic [31:0] SAT_EXP = 32'h0000_7FFF;
`else
   localparam logic [31:0] SAT_EXP = 32'hFFFF_CA24;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   npu_mac_array_if bus ();

   npu_mac_array #(.NUM_PE(4), .ACC_W(24), .K_MAX(9), .OFIFO_DEPTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .host_if (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic        rd_seen;
   logic [31:0] mon_exp;
   string       mon_tag;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] sel, input logic [31:0] d);
      bus.ena   = 1'b1;
      bus.wea   = 1'b1;
      bus.addra = {1'b0, sel, 12'h000};
      bus.dina  = d;
      @(negedge clk);
      bus.ena   = 1'b0;
      bus.wea   = 1'b0;
   endtask

   task automatic rd(input logic [2:0] sel, input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      bus.ena   = 1'b1;
      bus.wea   = 1'b0;
      bus.addra = {1'b0, sel, 12'h000};
      @(negedge clk);
      bus.ena   = 1'b0;
   endtask

   task automatic step_wait(input int n);
      wr(SEL_CMD, 32'h1);
      idle(n);
   endtask

   // A read issued in one cycle presents its data on douta from the next edge.
   always @(posedge clk or posedge rst) begin
      if (rst) rd_seen <= 1'b0;
      else     rd_seen <= bus.ena & ~bus.wea;
   end

   always begin : monitor
      @(negedge clk or posedge rst);
      if (rst) begin
         #1;
         total++;
         if (bus.douta !== 32'h0) begin
            bad++;
            $display("FAIL rst_douta got=%h want=%h", bus.douta, 32'h0);
         end
      end else if (rd_seen) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_read got=%h want=<none>", bus.douta);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            if (bus.douta !== mon_exp) begin
               bad++;
               $display("FAIL %s got=%h want=%h", mon_tag, bus.douta, mon_exp);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stimulus
      bus.ena   = 1'b0;
      bus.wea   = 1'b0;
      bus.addra = 16'h0000;
      bus.dina  = 32'h0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(1);

      rd(SEL_STAT, 32'h0000_0002, "reset_status");
      rd(SEL_RES,  32'h0000_0000, "empty_pop");
      rd(SEL_STAT, 32'h0000_0012, "underflow_flag");
      rd(SEL_STAT, 32'h0000_0002, "err_cleared");

      // reduce mode, 9 taps of 1*2 on 4 lanes = 72
      wr(SEL_CFG, 32'h0000_0009);
      wr(SEL_ACT, 32'h0101_0101);
      wr(SEL_WGT, 32'h0202_0202);
      repeat (8) step_wait(1);
      wr(SEL_CMD, 32'h1);
      idle(3);
      rd(SEL_STAT, 32'h0000_0003, "final_tap_busy");
      rd(SEL_STAT, 32'h0000_0100, "first_push_visible");
      rd(SEL_RES,  32'h0000_0048, "reduce_9tap");
      rd(SEL_STAT, 32'h0000_0002, "reduce_drained");

      // shift by 2 of -64, then ReLU
      wr(SEL_CFG, 32'h0000_0201);
      wr(SEL_ACT, 32'h1010_1010);
      wr(SEL_WGT, 32'hFFFF_FFFF);
      step_wait(6);
      rd(SEL_RES, 32'hFFFF_FFF0, "shift_no_relu");
      rd(3'd7,    32'h0000_0000, "unmapped_read");
      wr(SEL_CFG, 32'h0000_0211);
      step_wait(6);
      rd(SEL_RES, 32'h0000_0000, "relu_clamp");

      // sign-extended activation: -1 * 127 * 4 = -508
      wr(SEL_CFG, 32'h0000_0021);
      wr(SEL_ACT, 32'hFFFF_FFFF);
      wr(SEL_WGT, 32'h7F7F_7F7F);
      step_wait(6);
      rd(SEL_RES, 32'hFFFF_FE04, "act_signed");

      // independent lanes
      wr(SEL_CFG, 32'h0000_0801);
      wr(SEL_ACT, 32'h0403_0201);
      wr(SEL_WGT, 32'h0303_0303);
      step_wait(8);
      rd(SEL_RES,  32'h0000_0003, "indep_lane0");
      rd(SEL_RES,  32'h0000_0006, "indep_lane1");
      rd(SEL_RES,  32'h0000_0009, "indep_lane2");
      rd(SEL_RES,  32'h0000_000C, "indep_lane3");
      rd(SEL_RES,  32'h0000_0000, "indep_underflow");
      rd(SEL_STAT, 32'h0000_0012, "indep_err_under");

      // STEP while busy, and CLR together with STEP (reduce 1 tap: sum 30)
      wr(SEL_CFG, 32'h0000_0001);
      wr(SEL_CMD, 32'h1);
      wr(SEL_CMD, 32'h1);
      idle(6);
      rd(SEL_STAT, 32'h0000_0108, "err_busy_set");
      rd(SEL_STAT, 32'h0000_0100, "err_busy_clear");
      rd(SEL_RES,  32'h0000_001E, "single_result");
      wr(SEL_CMD, 32'h3);
      idle(6);
      rd(SEL_STAT, 32'h0000_0002, "clr_beats_step");

      // CLR after two of three taps, then a fresh 1-tap result
      wr(SEL_CFG, 32'h0000_0003);
      step_wait(1);
      step_wait(1);
      wr(SEL_CMD, 32'h2);
      wr(SEL_CFG, 32'h0000_0001);
      step_wait(6);
      rd(SEL_RES, 32'h0000_001E, "clr_fresh_product");

      // taps=15 clamps to 9: 255*127*4*9 = 1165860
      wr(SEL_CFG, 32'h0000_000F);
      wr(SEL_ACT, 32'hFFFF_FFFF);
      wr(SEL_WGT, 32'h7F7F_7F7F);
      repeat (8) step_wait(1);
      step_wait(6);
      rd(SEL_RES, SAT_EXP, "saturation");

      // fill the FIFO, stall a ninth push, release it with one pop
      wr(SEL_CFG, 32'h0000_0001);
      wr(SEL_ACT, 32'h0403_0201);
      wr(SEL_WGT, 32'h0303_0303);
      repeat (8) step_wait(6);
      rd(SEL_STAT, 32'h0000_0804, "fifo_full");
      step_wait(6);
      rd(SEL_STAT, 32'h0000_0805, "push_stalled");
      rd(SEL_RES,  32'h0000_001E, "pop_full");
      rd(SEL_STAT, 32'h0000_0701, "pop_release");
      rd(SEL_STAT, 32'h0000_0804, "refilled");
      wr(SEL_CMD, 32'h4);
      rd(SEL_STAT, 32'h0000_0002, "flush_empty");

      // asynchronous reset while a push is stalled
      repeat (8) step_wait(6);
      step_wait(6);
      rd(SEL_STAT, 32'h0000_0805, "stall_before_rst");
      #2;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      rd(SEL_STAT, 32'h0000_0002, "status_after_rst");
      rd(SEL_RES,  32'h0000_0000, "pop_after_rst");

      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
